hdmi_fetch_ctrl: RTL and testbench

Read scheduler between hdmi_core's fetch strobes and the DDR2 read-master port. It turns read_go/read_next_line/read_next_chunk/read_done pulses into a prefetching stream of fixed-size burst requests. Addresses are walked over one of two framebuffers, with the buffer swap taken only at frame boundaries. It also flags pixel-FIFO underrun when the display consumes a chunk that was never requested.

---
 rtl/hdmi_fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hdmi_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_fetch_ctrl.sv
// Read scheduler between hdmi_core fetch strobes and the DDR2 read-master port.
// Prefetches fixed-size bursts over a double-buffered framebuffer and flags pixel-FIFO underrun.
module hdmi_fetch_ctrl #(
    parameter int unsigned CHUNK_PIX = 64,
    parameter int unsigned PREFETCH  = 2,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [10:0]       hres,
    input  logic [ADDR_W-1:0] fb_base_a,
    input  logic [ADDR_W-1:0] fb_base_b,
    input  logic              swap_req,
    input  logic              read_go,
    input  logic              read_next_line,
    input  logic              read_next_chunk,
    input  logic              read_done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [6:0]        rd_len,
    input  logic              rd_ack,
    output logic              buf_sel,
    output logic              swap_pending,
    output logic              underrun,
    output logic              busy
);

    localparam int unsigned HRES_W      = 11;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned SUM_W       = CNT_W + 1;
    localparam int unsigned LEN_W       = 7;
    localparam int unsigned CHUNK_BYTES = CHUNK_PIX * 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  cpl;
    logic [LEN_W-1:0]  last_len;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  consumed;
    logic [CNT_W-1:0]  pend;
    logic              nl_pend;

    // Line geometry derived from hres, captured only at read_go
    logic [HRES_W-1:0] hres_div;
    logic [HRES_W-1:0] hres_mod;
    logic [CNT_W-1:0]  cpl_go;
    logic [LEN_W-1:0]  last_len_go;
    logic [CNT_W-1:0]  pend_go;
    logic [ADDR_W-1:0] stride_go;

    assign hres_div    = hres / HRES_W'(CHUNK_PIX);
    assign hres_mod    = hres % HRES_W'(CHUNK_PIX);
    assign cpl_go      = CNT_W'(hres_div) + CNT_W'(hres_mod != '0);
    assign last_len_go = (hres_mod == '0) ? LEN_W'(CHUNK_PIX) : LEN_W'(hres_mod);
    assign pend_go     = (CNT_W'(PREFETCH) < cpl_go) ? CNT_W'(PREFETCH) : cpl_go;
    assign stride_go   = ADDR_W'({hres, 2'b00});

    // Per-cycle counter updates from transfers and chunk strobes
    logic             xfer;
    logic             chunk;
    logic             ur_set;
    logic             do_reload;
    logic [CNT_W-1:0] issued_x;
    logic [CNT_W-1:0] consumed_x;
    logic [CNT_W-1:0] pend_x;
    logic [CNT_W-1:0] pend_init;

    always_comb begin
        xfer       = rd_req && rd_ack;
        chunk      = read_next_chunk && (state != S_IDLE);
        issued_x   = issued;
        consumed_x = consumed;
        pend_x     = pend;
        if (xfer) begin
            if (issued < cpl) issued_x = issued + CNT_W'(1);
            if (pend != '0)   pend_x   = pend - CNT_W'(1);
        end
        if (chunk) begin
            if (consumed < cpl) consumed_x = consumed + CNT_W'(1);
            if ((SUM_W'(issued) + SUM_W'(pend)) < SUM_W'(cpl)) pend_x = pend_x + CNT_W'(1);
        end
        ur_set    = chunk && (issued == consumed);
        // A line strobe during an open request is deferred to that request's transfer
        do_reload = ((state == S_LINE) && read_next_line && !read_done) ||
                    ((state == S_REQ) && xfer && (read_next_line || nl_pend));
        pend_init = (CNT_W'(PREFETCH) < cpl) ? CNT_W'(PREFETCH) : cpl;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            rd_len       <= '0;
            buf_sel      <= 1'b0;
            swap_pending <= 1'b0;
            underrun     <= 1'b0;
            busy         <= 1'b0;
            line_addr    <= '0;
            stride       <= '0;
            cpl          <= '0;
            last_len     <= '0;
            issued       <= '0;
            consumed     <= '0;
            pend         <= '0;
            nl_pend      <= 1'b0;
        end else begin
            if (swap_req) swap_pending <= 1'b1;

            if (state != S_IDLE) begin
                issued   <= issued_x;
                consumed <= consumed_x;
                pend     <= pend_x;
                if (ur_set) underrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (read_go) begin
                        line_addr <= buf_sel ? fb_base_b : fb_base_a;
                        cpl       <= cpl_go;
                        last_len  <= last_len_go;
                        stride    <= stride_go;
                        issued    <= '0;
                        consumed  <= '0;
                        pend      <= pend_go;
                        nl_pend   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LINE;
                    end
                end
                S_LINE: begin
                    if (read_done) begin
                        state <= S_DRAIN;
                    end else if (!read_next_line && (pend != '0)) begin
                        rd_addr <= line_addr + ADDR_W'(issued) * ADDR_W'(CHUNK_BYTES);
                        rd_len  <= (issued == (cpl - CNT_W'(1))) ? last_len : LEN_W'(CHUNK_PIX);
                        rd_req  <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (xfer) begin
                        rd_req  <= 1'b0;
                        nl_pend <= 1'b0;
                        state   <= read_done ? S_DRAIN : S_LINE;
                    end else begin
                        if (read_next_line) nl_pend <= 1'b1;
                        if (read_done)      state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    nl_pend <= 1'b0;
                    if (!rd_req || rd_ack) begin
                        rd_req <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                        // Buffer swap is only taken at the frame boundary
                        if (swap_pending) begin
                            buf_sel      <= ~buf_sel;
                            swap_pending <= swap_req;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (do_reload) begin
                line_addr <= line_addr + stride;
                issued    <= '0;
                consumed  <= '0;
                pend      <= pend_init;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_fetch_ctrl.sv
// Directed bench for hdmi_fetch_ctrl: burst addresses/lengths, prefetch, handshake hold,
// underrun, buffer swap and reset behaviour against hand-computed values.
module tb_hdmi_fetch_ctrl;

    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'h8000_0000;
    localparam int ST_GO    = 0;
    localparam int ST_LINE  = 1;
    localparam int ST_CHUNK = 2;
    localparam int ST_DONE  = 3;
    localparam int ST_SWAP  = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] hres;
    logic [31:0] fb_base_a;
    logic [31:0] fb_base_b;
    logic        swap_req;
    logic        read_go;
    logic        read_next_line;
    logic        read_next_chunk;
    logic        read_done;
    logic        rd_ack;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic [6:0]  rd_len;
    logic        buf_sel;
    logic        swap_pending;
    logic        underrun;
    logic        busy;

    logic        rq1;
    logic [31:0] ad1;
    logic [6:0]  ln1;
    logic        bs1;
    logic        sp1;
    logic        ur1;
    logic        bz1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_addr[$];
    logic [6:0]  q_len[$];

    always #5 clock = ~clock;

    hdmi_fetch_ctrl #(.CHUNK_PIX(64), .PREFETCH(2), .ADDR_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .hres(hres),
        .fb_base_a(fb_base_a), .fb_base_b(fb_base_b), .swap_req(swap_req),
        .read_go(read_go), .read_next_line(read_next_line),
        .read_next_chunk(read_next_chunk), .read_done(read_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .buf_sel(buf_sel), .swap_pending(swap_pending), .underrun(underrun), .busy(busy)
    );

    hdmi_fetch_ctrl #(.CHUNK_PIX(64), .PREFETCH(1), .ADDR_W(32)) u_dut_pf1 (
        .clock(clock), .reset_n(reset_n), .hres(hres),
        .fb_base_a(fb_base_a), .fb_base_b(fb_base_b), .swap_req(swap_req),
        .read_go(read_go), .read_next_line(read_next_line),
        .read_next_chunk(read_next_chunk), .read_done(read_done),
        .rd_req(rq1), .rd_addr(ad1), .rd_len(ln1), .rd_ack(rd_ack),
        .buf_sel(bs1), .swap_pending(sp1), .underrun(ur1), .busy(bz1)
    );

    // Record every accepted burst of the PREFETCH=2 instance
    always @(posedge clock) begin
        if (reset_n && rd_req && rd_ack) begin
            q_addr.push_back(rd_addr);
            q_len.push_back(rd_len);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input int which);
        case (which)
            ST_GO:    read_go = 1'b1;
            ST_LINE:  read_next_line = 1'b1;
            ST_CHUNK: read_next_chunk = 1'b1;
            ST_DONE:  read_done = 1'b1;
            default:  swap_req = 1'b1;
        endcase
        tick(1);
        read_go = 1'b0;
        read_next_line = 1'b0;
        read_next_chunk = 1'b0;
        read_done = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        q_addr.delete();
        q_len.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        hres = 11'd640;
        fb_base_a = BASE_A;
        fb_base_b = BASE_B;
        swap_req = 1'b0;
        read_go = 1'b0;
        read_next_line = 1'b0;
        read_next_chunk = 1'b0;
        read_done = 1'b0;
        rd_ack = 1'b1;
        do_reset();

        check("rst_rd_req",   32'(rd_req), 32'd0);
        check("rst_rd_addr",  rd_addr, 32'd0);
        check("rst_rd_len",   32'(rd_len), 32'd0);
        check("rst_buf_sel",  32'(buf_sel), 32'd0);
        check("rst_swap_pnd", 32'(swap_pending), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_pf1_outs", {21'd0, rq1, bs1, sp1, ur1, bz1, ln1}, 32'd0);
        check("rst_pf1_addr", ad1, 32'd0);

        // 640 wide, ack always ready: two prefetched bursts, one per chunk after that
        strobe(ST_GO);
        tick(8);
        check("w640_prefetch_n", 32'(q_addr.size()), 32'd2);
        check("w640_req0_addr", q_addr[0], 32'h1000);
        check("w640_req0_len",  32'(q_len[0]), 32'd64);
        check("w640_req1_addr", q_addr[1], 32'h1100);
        check("w640_busy",      32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            strobe(ST_CHUNK);
            tick(4);
        end
        check("w640_line_n",    32'(q_addr.size()), 32'd10);
        check("w640_req9_addr", q_addr[9], 32'h1900);
        check("w640_req9_len",  32'(q_len[9]), 32'd64);
        strobe(ST_LINE);
        tick(8);
        check("w640_nl_n",       32'(q_addr.size()), 32'd12);
        check("w640_nl_addr0",   q_addr[10], 32'h1A00);
        check("w640_nl_addr1",   q_addr[11], 32'h1B00);
        check("w640_underrun",   32'(underrun), 32'd0);
        strobe(ST_DONE);
        tick(3);
        check("w640_done_busy",  32'(busy), 32'd0);

        // 800 wide: 13 bursts per line, short final burst
        do_reset();
        hres = 11'd800;
        strobe(ST_GO);
        tick(8);
        for (int i = 0; i < 11; i++) begin
            strobe(ST_CHUNK);
            tick(4);
        end
        check("w800_line_n",     32'(q_addr.size()), 32'd13);
        check("w800_req11_len",  32'(q_len[11]), 32'd64);
        check("w800_req12_addr", q_addr[12], 32'h1C00);
        check("w800_req12_len",  32'(q_len[12]), 32'd32);
        for (int i = 0; i < 3; i++) begin
            strobe(ST_CHUNK);
            tick(4);
        end
        check("w800_no_extra",   32'(q_addr.size()), 32'd13);
        check("w800_no_req",     32'(rd_req), 32'd0);

        // Held-off acknowledge: request stays frozen; chunk coincident with ack keeps pend
        do_reset();
        hres = 11'd640;
        rd_ack = 1'b0;
        strobe(ST_GO);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("hold_rd_req",  32'(rd_req), 32'd1);
            check("hold_rd_addr", rd_addr, 32'h1000);
            check("hold_rd_len",  32'(rd_len), 32'd64);
            tick(1);
        end
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        tick(1);
        check("hold_req1_addr", rd_addr, 32'h1100);
        check("hold_req1_req",  32'(rd_req), 32'd1);
        read_next_chunk = 1'b1;
        rd_ack = 1'b1;
        tick(1);
        read_next_chunk = 1'b0;
        tick(8);
        check("coinc_n",        32'(q_addr.size()), 32'd3);
        check("coinc_addr2",    q_addr[2], 32'h1200);
        check("coinc_underrun", 32'(underrun), 32'd0);

        // PREFETCH=1 with ack low: display outruns fetch, underrun is sticky
        do_reset();
        rd_ack = 1'b0;
        strobe(ST_GO);
        tick(2);
        strobe(ST_CHUNK);
        tick(1);
        strobe(ST_CHUNK);
        tick(1);
        check("pf1_underrun",      32'(ur1), 32'd1);
        strobe(ST_DONE);
        check("pf1_drain_busy",    32'(bz1), 32'd1);
        rd_ack = 1'b1;
        tick(3);
        check("pf1_idle_busy",     32'(bz1), 32'd0);
        check("pf1_underrun_done", 32'(ur1), 32'd1);
        strobe(ST_GO);
        tick(4);
        check("pf1_underrun_next", 32'(ur1), 32'd1);
        check("pf1_next_busy",     32'(bz1), 32'd1);

        // Swap requested mid-frame takes effect only at frame end
        do_reset();
        rd_ack = 1'b1;
        strobe(ST_GO);
        tick(6);
        strobe(ST_SWAP);
        tick(2);
        check("swap_pending_set", 32'(swap_pending), 32'd1);
        check("swap_bufsel_hold", 32'(buf_sel), 32'd0);
        strobe(ST_CHUNK);
        tick(4);
        check("swap_pending_mid", 32'(swap_pending), 32'd1);
        check("swap_bufsel_mid",  32'(buf_sel), 32'd0);
        strobe(ST_DONE);
        tick(3);
        check("swap_bufsel_done", 32'(buf_sel), 32'd1);
        check("swap_pending_clr", 32'(swap_pending), 32'd0);
        q_addr.delete();
        q_len.delete();
        strobe(ST_GO);
        tick(4);
        check("swap_b_n",    32'(q_addr.size() >= 1), 32'd1);
        check("swap_b_addr", q_addr[0], BASE_B);

        // Reset asserted while a request is open
        do_reset();
        rd_ack = 1'b0;
        strobe(ST_GO);
        tick(1);
        check("rreq_open", 32'(rd_req), 32'd1);
        reset_n = 1'b0;
        tick(1);
        check("rreq_rd_req", 32'(rd_req), 32'd0);
        check("rreq_busy",   32'(busy), 32'd0);
        check("rreq_rd_len", 32'(rd_len), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) strobe(ST_CHUNK);
        tick(2);
        check("idle_chunk_underrun", 32'(underrun), 32'd0);
        check("idle_chunk_rd_req",   32'(rd_req), 32'd0);
        check("idle_chunk_busy",     32'(busy), 32'd0);

        // Line strobe while a request is open: old burst completes, then new line
        do_reset();
        rd_ack = 1'b0;
        strobe(ST_GO);
        tick(1);
        strobe(ST_LINE);
        check("nlreq_addr_held", rd_addr, 32'h1000);
        rd_ack = 1'b1;
        tick(8);
        check("nlreq_n",     32'(q_addr.size()), 32'd3);
        check("nlreq_addr0", q_addr[0], 32'h1000);
        check("nlreq_addr1", q_addr[1], 32'h1A00);
        check("nlreq_addr2", q_addr[2], 32'h1B00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
